// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial frame deserializer.
// State encoding, line levels and the counter-width helper live here.
package serial_deser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Never returns 0, so a 2-bit frame still gets a usable 1-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-in, parallel-out shift register for the deserializer.
// LSB_FIRST selects whether the first bit shifted in ends up in q[0] or q[DATA_W-1].
module deser_shift_reg #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              si,
  input  logic              clear,
  output logic [DATA_W-1:0] q
);

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           q <= '0;
        else if (clear)    q <= '0;
        else if (shift_en) q <= {si, q[DATA_W-1:1]};
      end
    end else begin : g_msb_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           q <= '0;
        else if (clear)    q <= '0;
        else if (shift_en) q <= {q[DATA_W-2:0], si};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_frame_deserializer.sv
// Start/stop framed serial receiver with a single-entry valid/ready output register.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit between data and stop.
module serial_frame_deserializer
  import serial_deser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              si,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CW = clog2(DATA_W);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] word;
  logic              shift_en;
  logic              clear;
  logic              last_bit;
  logic              parity_ok;
  logic              word_done;

  assign shift_en = bit_en && (state == S_DATA);
  assign clear    = bit_en && (state == S_IDLE) && (si == START_LEVEL);
  assign last_bit = (cnt == CW'(DATA_W - 1));

`ifdef SERIAL_DESER_PARITY_EN
  logic par_bit;
  assign parity_ok = ~^{word, par_bit};
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // A good stop bit with matching parity is the only way a word reaches the output.
  assign word_done = bit_en && (state == S_STOP) && (si == IDLE_LEVEL) && parity_ok;

  deser_shift_reg #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk     (CLK),
    .rst     (RES),
    .shift_en(shift_en),
    .si      (si),
    .clear   (clear),
    .q       (word)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      parity_err <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif

      // The holding register may be refilled on the same edge the consumer drains it.
      if (word_done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= word;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (bit_en) begin
        case (state)
          S_IDLE: begin
            if (si == START_LEVEL) begin
              state <= S_DATA;
              cnt   <= '0;
            end
          end
          S_DATA: begin
            cnt <= cnt + 1'b1;
            if (last_bit) begin
`ifdef SERIAL_DESER_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
`ifdef SERIAL_DESER_PARITY_EN
          S_PARITY: begin
            par_bit <= si;
            state   <= S_STOP;
          end
`endif
          S_STOP: begin
            if (si == IDLE_LEVEL) begin
`ifdef SERIAL_DESER_PARITY_EN
              if (!parity_ok) parity_err <= 1'b1;
`endif
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (si == IDLE_LEVEL) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
Downstream stage of the serial shift-register chain. Consumes the 1-bit serial stream (`so` of the shift stage) and detects start/stop framing. Assembles DATA_W-bit words and presents them on a parallel port with a valid/ready handshake. Single-entry output holding register; framing and overrun errors are flagged.

Parameters:
- DATA_W, 8, number of data bits per frame (2..32).
- LSB_FIRST, 1, 1 = first received data bit lands in dout[0]; 0 = first bit lands in dout[DATA_W-1].

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RES  input  1  asynchronous, active-high reset.
- si  input  1  serial line; idle level 1.
- bit_en  input  1  sample strobe; si is sampled only on edges where bit_en=1.
- dout  output  DATA_W  received word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: completed word dropped because holding register full.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when PARITY_EN is undefined.

Behaviour:
- Reset (async, RES=1): state=IDLE, dout=0, dout_valid=0, frame_err=0, overrun=0, parity_err=0, bit counter=0, shift register=0.
- Sampled bits: all FSM transitions below occur only on edges with bit_en=1. Otherwise state, counter and shift register hold.
- The handshake is independent of bit_en and is evaluated every edge.
- FSM states: IDLE, DATA, PARITY (only with PARITY_EN), STOP, WAIT_IDLE.
- IDLE: si=0 → DATA, counter=0. si=1 → stay.
- DATA: shift si in per LSB_FIRST and increment counter. When counter==DATA_W-1 → PARITY if enabled, else STOP.
- STOP with si=1 → word complete → IDLE.
- STOP with si=0 → frame_err pulse, word discarded → WAIT_IDLE.
- WAIT_IDLE: stay until sampled si=1, then → IDLE. A 0 held on the line must not re-trigger a start.
- Word complete, holding register empty, or being consumed this same edge (dout_valid && dout_ready) → dout loads the new word and dout_valid=1.
- Latency: dout_valid is high in the cycle after the stop-bit sampling edge.
- Word complete while dout_valid=1 && dout_ready=0 → new word dropped, dout unchanged, overrun pulse.
- dout_valid && dout_ready with no completing word → dout_valid=0; dout keeps its last value.
- Error pulses are registered, high exactly one cycle, and never coincident with a dout load from the same frame.
- RES asserted mid-frame → immediate return to IDLE; any pending dout is lost.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined: one even-parity bit follows the data bits (PARITY state).
- With the macro, parity is checked in STOP. The XOR of data bits and parity bit must be 0.
- On parity mismatch with a good stop bit: parity_err pulse, word dropped, → IDLE.
- On a bad stop bit: frame_err takes precedence and parity_err is not raised.
- Undefined: no PARITY state; parity_err driven constant 0; frame length is 1+DATA_W+1 sampled bits.

Decomposition:
- Package serial_deser_pkg: state enum typedef, IDLE_LEVEL=1'b1, START_LEVEL=1'b0, and a counter-width function clog2(DATA_W).
- Sub-module deser_shift_reg: parameterised DATA_W, LSB_FIRST. Inputs are shift enable, si and clear; output is the parallel word.
- FSM, counter, holding register and error logic stay in the top module.

Test Plan:
- Basic frame: bit_en=1, DATA_W=8, LSB_FIRST=1, si sequence 0,1,0,1,0,0,1,0,1,1 → dout=8'hA5 and dout_valid=1 one cycle after the stop sample. Holding dout_ready=0 keeps it; dout_ready=1 for one cycle clears dout_valid.
- Framing error: send 0 + 8'h3C data + stop=0, then hold si=0 for 5 samples → frame_err single pulse, dout_valid stays 0, no new start detected until si=1 then 0.
- Overrun: receive 8'h11 with dout_ready=0, then 8'h22 → overrun pulse at second completion, dout remains 8'h11.
- Simultaneous: accept 8'h11 (dout_ready=1) on the same edge that 8'h22 completes → dout=8'h22, dout_valid stays 1, no overrun.
- bit_en gating plus mid-frame reset: bit_en toggling 1,0,1,0 → result is identical to the basic frame. RES pulsed after 4 data bits → all outputs 0 and state IDLE; the next full frame 8'hC3 is received correctly.
- With SERIAL_DESER_PARITY_EN: 8'hA5 with parity 0 → accepted. Same frame with parity 1 → parity_err pulse, dout_valid=0.
